lbp_hist: RTL
=============

LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 Parameter CNT_W, default 14, width of each histogram bin count.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 lbp_valid  input  1  one LBP code present this cycle; no backpressure.
REQ-005 lbp_addr  input  14  pixel address of code; used only for the end-of-frame check.
REQ-006 lbp_data  input  8  LBP code.
REQ-007 finish  input  1  frame complete, level or pulse; sampled in ACCUM only.
REQ-008 hist_ready  input  1  downstream accepts current bin.
REQ-009 hist_valid  output  1  hist_bin/hist_count valid.
REQ-010 hist_bin  output  8  bin index.
REQ-011 hist_count  output  CNT_W  bin count.
REQ-012 hist_done  output  1  one-cycle pulse after the last bin is accepted.
REQ-013 busy  output  1  high in CLEAR, DRAIN and READ.
REQ-014 drop_err  output  1  sticky; a code arrived while busy.

Function
REQ-015 FSM states: CLEAR, ACCUM, DRAIN, READ.
- CLEAR->ACCUM after all NBINS bins are zeroed, one bin per cycle.
- ACCUM->DRAIN when finish=1.
- DRAIN->READ after 2 cycles.
- READ->CLEAR on the accepted handshake of the last bin.
REQ-016 NBINS = 256; bin storage is a single-port-per-direction array (1 read, 1 write per cycle).
REQ-017 Accumulation is a 2-stage read-modify-write: stage 1 reads the bin; stage 2 writes count+1.
REQ-018 Back-to-back codes to the same bin are bypassed from stage 2, so N consecutive identical codes add exactly N.
REQ-019 Counts saturate at 2^CNT_W-1; no wrap.
REQ-020 A code accepted in ACCUM on the same cycle finish rises is counted. DRAIN flushes the pipeline before READ.
REQ-021 READ presents bins 0..NBINS-1 in ascending order. hist_valid holds with stable bin/count until hist_valid&hist_ready, then advances next cycle.
REQ-022 hist_done is asserted the cycle after the last handshake, concurrent with entry to CLEAR.
REQ-023 A code with lbp_valid=1 while busy is discarded and sets drop_err. drop_err clears only on reset.
REQ-024 lbp_addr=16254 with lbp_valid in ACCUM is treated as an implicit finish, equivalent to finish=1.

Reset
REQ-025 Reset values: hist_valid=0, hist_bin=0, hist_count=0, hist_done=0, busy=1, drop_err=0; state=CLEAR; clear index=0; pipeline valid bits=0.
REQ-026 Reset asserted in any state, including mid-READ or mid-RMW, aborts the operation. The block restarts the full CLEAR; no partial count survives.

Configuration
REQ-027 Macro LBP_HIST_UNIFORM_EN.
- Defined: codes are mapped through a uniform-pattern LUT before binning. Codes with ≤2 circular bit transitions map to bins 0..57 in ascending code order; all others map to bin 58. NBINS=59, so CLEAR and READ span 59 bins.
- Undefined: identity mapping, NBINS=256.
REQ-028 The LUT adds no latency; it sits combinationally in stage 1.

Structure
REQ-029 Shared package lbp_pkg holds:
- state encoding typedef;
- NBINS_FULL=256, NBINS_UNI=59, LAST_PIX_ADDR=16254;
- the uniform-map function.
REQ-030 Sub-module lbp_hist_ram (NBINS×CNT_W, 1R1W, synchronous write, combinational read) holds storage. FSM, RMW pipeline and readout stay in lbp_hist.

Verification
REQ-031 Reset, wait for busy=0 (256 cycles), no codes, finish -> READ emits 256 bins all count 0, then one hist_done pulse.
REQ-032 Codes 5,5,5,7 back-to-back, then finish -> bin5=3, bin7=1, others 0.
REQ-033 hist_ready toggled 1,0,0,1 during READ -> each bin is held while ready=0; no bin is skipped or repeated.
REQ-034 CNT_W=4, 20 codes of value 9 -> bin9=15 (saturated).
REQ-035 lbp_valid during CLEAR and during READ -> code is not counted; drop_err=1 until reset.
REQ-036 With LBP_HIST_UNIFORM_EN: codes 0x00, 0xFF, 0x55 -> bin0=1, bin57=1, bin58=1; READ length is 59. Reset mid-READ -> full CLEAR restarts and hist_done does not pulse.

Source files
------------

// File: rtl/lbp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_pkg
//  Description : Shared types, constants and the uniform-pattern bin map for
//                the LBP histogram block.
//  Revision    : 1.0 - initial release
// ============================================================================
package lbp_pkg;

    // Histogram controller states
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    localparam int          NBINS_FULL    = 256;
    localparam int          NBINS_UNI     = 59;
    localparam logic [13:0] LAST_PIX_ADDR = 14'd16254;
    localparam logic [7:0]  UNI_OTHER_BIN = 8'd58;

    // Number of 0/1 changes walking once around the 8-bit circle
    function automatic logic [3:0] circ_transitions(input logic [7:0] code);
        logic [7:0] diff;
        logic [3:0] n;
        diff = code ^ {code[0], code[7:1]};
        n    = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, diff[i]};
        end
        return n;
    endfunction

    // Uniform codes (<=2 transitions) get their rank among uniform codes in
    // ascending order (0..57); every other code shares the last bin (58).
    // Intended for elaboration-time table building only.
    function automatic logic [7:0] uniform_map(input logic [7:0] code);
        logic [7:0] rank;
        if (circ_transitions(code) > 4'd2) begin
            return UNI_OTHER_BIN;
        end
        rank = '0;
        for (int i = 0; i < 256; i++) begin
            if ((i < int'(code)) && (circ_transitions(8'(i)) <= 4'd2)) begin
                rank = rank + 8'd1;
            end
        end
        return rank;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lbp_hist_ram.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_hist_ram
//  Description : Histogram bin storage, one read and one write port.
//                Synchronous write, combinational (asynchronous) read.
//  Revision    : 1.0 - initial release
// ============================================================================
module lbp_hist_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 14
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Single write port; contents are defined by the owner's clear sweep
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/lbp_hist.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_hist
//  Description : LBP code histogram. Clears the bins, accumulates codes with
//                a 2-stage read-modify-write (saturating, with same-bin
//                bypass), drains the pipeline, then streams bins out with a
//                valid/ready handshake.
//  Config      : define LBP_HIST_UNIFORM_EN to bin codes through the uniform
//                pattern map (59 bins) instead of the identity (256 bins).
//  Revision    : 1.0 - initial release
// ============================================================================
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    input  logic             hist_ready,
    output logic             hist_valid,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_done,
    output logic             busy,
    output logic             drop_err
);

`ifdef LBP_HIST_UNIFORM_EN
    localparam int NBINS = NBINS_UNI;
`else
    localparam int NBINS = NBINS_FULL;
`endif
    localparam logic [7:0]       LAST_BIN = 8'(NBINS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_idx;        // clear sweep / drain counter / read index
    logic             r_s2_vld;
    logic [7:0]       r_s2_bin;
    logic [CNT_W-1:0] r_s2_cnt;
    logic             r_done;
    logic             r_drop;

    logic [7:0]       w_bin;
    logic             w_accept;
    logic             w_fin;
    logic             w_hs;
    logic             w_last_hs;
    logic [7:0]       w_raddr;
    logic [CNT_W-1:0] w_rdata;
    logic [CNT_W-1:0] w_cur;
    logic [CNT_W-1:0] w_inc;
    logic             w_we;
    logic [7:0]       w_waddr;
    logic [CNT_W-1:0] w_wdata;

`ifdef LBP_HIST_UNIFORM_EN
    // Constant table built at elaboration; purely combinational in stage 1
    logic [7:0] w_lut [256];
    for (genvar g = 0; g < 256; g++) begin : g_lut
        localparam logic [7:0] C_BIN = uniform_map(8'(g));
        assign w_lut[g] = C_BIN;
    end
    assign w_bin = w_lut[lbp_data];
`else
    assign w_bin = lbp_data;
`endif

    assign w_accept  = lbp_valid && (r_state == ST_ACCUM);
    // Last pixel address acts as an implicit finish
    assign w_fin     = (r_state == ST_ACCUM) &&
                       (finish || (w_accept && (lbp_addr == LAST_PIX_ADDR)));
    assign w_hs      = hist_valid && hist_ready;
    assign w_last_hs = w_hs && (r_idx == LAST_BIN);

    // Stage 1: read the bin, bypassing the count still in flight in stage 2
    assign w_raddr = (r_state == ST_READ) ? r_idx : w_bin;
    assign w_cur   = (r_s2_vld && (r_s2_bin == w_bin)) ? r_s2_cnt : w_rdata;
    assign w_inc   = (w_cur == CNT_MAX) ? CNT_MAX : w_cur + {{(CNT_W-1){1'b0}}, 1'b1};

    // Write port: zeroing sweep in CLEAR, otherwise stage-2 write-back
    assign w_we    = (r_state == ST_CLEAR) || r_s2_vld;
    assign w_waddr = (r_state == ST_CLEAR) ? r_idx : r_s2_bin;
    assign w_wdata = (r_state == ST_CLEAR) ? '0 : r_s2_cnt;

    lbp_hist_ram #(
        .DEPTH (NBINS),
        .AW    (8),
        .DW    (CNT_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_idx == LAST_BIN) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_fin)             w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_idx == 8'd1)     w_state_nxt = ST_READ;
            ST_READ:  if (w_last_hs)         w_state_nxt = ST_CLEAR;
            default:                         w_state_nxt = ST_CLEAR;
        endcase
    end

    // Shared index: restarts on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (r_state != w_state_nxt) begin
            r_idx <= '0;
        end else if ((r_state == ST_CLEAR) || (r_state == ST_DRAIN) || w_hs) begin
            r_idx <= r_idx + 8'd1;
        end
    end

    // Stage 2 register: incremented count waiting for write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_vld <= 1'b0;
            r_s2_bin <= '0;
            r_s2_cnt <= '0;
        end else begin
            r_s2_vld <= w_accept;
            r_s2_bin <= w_bin;
            r_s2_cnt <= w_inc;
        end
    end

    // Done pulse after the final handshake; sticky drop flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_done <= w_last_hs;
            r_drop <= r_drop || (lbp_valid && (r_state != ST_ACCUM));
        end
    end

    assign busy       = (r_state != ST_ACCUM);
    assign hist_valid = (r_state == ST_READ);
    assign hist_bin   = hist_valid ? r_idx : '0;
    assign hist_count = hist_valid ? w_rdata : '0;
    assign hist_done  = r_done;
    assign drop_err   = r_drop;

endmodule
`default_nettype wire
